reg_file: RTL and testbench

- Architectural register file for the out-of-order RISC-V core: 32 x 32-bit values plus one rename tag per register.
- The tag holds the ROB entry that will produce the register's next value; tag 0 means the register is not renamed.
- The ROB renames a destination at issue (reorder), writes the value and clears the tag at commit (modify), and reads operands for dispatch (query).

---
 rtl/reg_file.sv | 83 ++++++++
 tb/tb_reg_file.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Architectural register file with per-register ROB rename tags for the out-of-order core.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle commit to the query port.
module reg_file #(
  parameter int ENTRY_W = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear,
  input  logic               query,
  input  logic [4:0]         query_index,
  output logic [ENTRY_W-1:0] query_entry,
  output logic [31:0]        query_value,
  input  logic               reorder,
  input  logic [ENTRY_W-1:0] reorder_entry,
  input  logic [4:0]         reorder_rd,
  input  logic               modify,
  input  logic [ENTRY_W-1:0] modify_entry,
  input  logic [4:0]         modify_index,
  input  logic [31:0]        modify_value
);

  logic [31:0]        value_q  [32];
  logic [ENTRY_W-1:0] tag_q    [32];
  logic [ENTRY_W-1:0] tag_next [32];

  // Commit clears a tag only if it still names the committing entry; flush beats rename, rename beats commit.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      tag_next[i] = tag_q[i];
      if (modify && (modify_index == 5'(i)) && (tag_q[i] == modify_entry)) begin
        tag_next[i] = '0;
      end
      if (clear) begin
        tag_next[i] = '0;
      end else if (reorder && (reorder_rd == 5'(i))) begin
        tag_next[i] = reorder_entry;
      end
    end
    tag_next[0] = '0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        tag_q[i] <= '0;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < 32; i++) begin
        tag_q[i] <= tag_next[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
      end
    end else if (rdy_in && modify && (modify_index != 5'd0)) begin
      value_q[modify_index] <= modify_value;
    end
  end

  always_comb begin
    query_entry = '0;
    query_value = '0;
    if (query && (query_index != 5'd0)) begin
      query_entry = tag_q[query_index];
      query_value = value_q[query_index];
`ifdef REGFILE_BYPASS_EN
      // Forwarding ignores rdy_in so dispatch sees the committing value immediately.
      if (modify && (modify_index == query_index)) begin
        query_value = modify_value;
        if (tag_q[query_index] == modify_entry) begin
          query_entry = '0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; honours REGFILE_BYPASS_EN when defined.
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        query;
  logic [4:0]  query_index;
  logic [3:0]  query_entry;
  logic [31:0] query_value;
  logic        reorder;
  logic [3:0]  reorder_entry;
  logic [4:0]  reorder_rd;
  logic        modify;
  logic [3:0]  modify_entry;
  logic [4:0]  modify_index;
  logic [31:0] modify_value;

  int checkCount = 0;
  int failCount  = 0;

  reg_file #(.ENTRY_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .query(query), .query_index(query_index),
    .query_entry(query_entry), .query_value(query_value),
    .reorder(reorder), .reorder_entry(reorder_entry), .reorder_rd(reorder_rd),
    .modify(modify), .modify_entry(modify_entry), .modify_index(modify_index),
    .modify_value(modify_value)
  );

  always #5 clk_in = ~clk_in;

  task automatic idleInputs();
    rdy_in = 1'b1; clear = 1'b0;
    reorder = 1'b0; reorder_entry = 4'd0; reorder_rd = 5'd0;
    modify = 1'b0; modify_entry = 4'd0; modify_index = 5'd0; modify_value = 32'd0;
  endtask

  // Presents one cycle of requests, clocks it in, then returns to idle just after the edge.
  task automatic applyStimulus(input logic ro, input logic [4:0] rd, input logic [3:0] re,
                               input logic mo, input logic [4:0] mi, input logic [3:0] me,
                               input logic [31:0] mv, input logic cl, input logic rdy);
    reorder = ro; reorder_rd = rd; reorder_entry = re;
    modify = mo; modify_index = mi; modify_entry = me; modify_value = mv;
    clear = cl; rdy_in = rdy;
    @(posedge clk_in);
    #1;
    idleInputs();
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] idx,
                             input logic [3:0] expEntry, input logic [31:0] expValue);
    query = 1'b1;
    query_index = idx;
    #1;
    checkCount++;
    assert (query_entry === expEntry) else begin
      failCount++;
      $error("[TB] FAIL %s.entry observed=%0d expected=%0d", tag, query_entry, expEntry);
    end
    checkCount++;
    assert (query_value === expValue) else begin
      failCount++;
      $error("[TB] FAIL %s.value observed=0x%08h expected=0x%08h", tag, query_value, expValue);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idleInputs();
    query = 1'b0; query_index = 5'd0;
    rst_in = 1'b0;
    #12;
    checkOutput("reset_x5", 5'd5, 4'd0, 32'd0);
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    applyStimulus(1, 5'd5, 4'd3, 0, 5'd0, 4'd0, 32'd0, 0, 1);
    checkOutput("rename_x5", 5'd5, 4'd3, 32'd0);
    applyStimulus(0, 5'd0, 4'd0, 1, 5'd5, 4'd3, 32'hDEADBEEF, 0, 1);
    checkOutput("commit_x5", 5'd5, 4'd0, 32'hDEADBEEF);

    applyStimulus(1, 5'd7, 4'd2, 0, 5'd0, 4'd0, 32'd0, 0, 1);
    applyStimulus(1, 5'd7, 4'd4, 0, 5'd0, 4'd0, 32'd0, 0, 1);
    applyStimulus(0, 5'd0, 4'd0, 1, 5'd7, 4'd2, 32'h11, 0, 1);
    checkOutput("stale_commit_x7", 5'd7, 4'd4, 32'h11);
    applyStimulus(0, 5'd0, 4'd0, 1, 5'd7, 4'd4, 32'h22, 0, 1);
    checkOutput("final_commit_x7", 5'd7, 4'd0, 32'h22);

    applyStimulus(1, 5'd9, 4'd6, 1, 5'd9, 4'd1, 32'h55, 0, 1);
    checkOutput("rename_wins_x9", 5'd9, 4'd6, 32'h55);
    // Commit matching the tag in the same cycle as a rename: rename still wins.
    applyStimulus(1, 5'd9, 4'd2, 1, 5'd9, 4'd6, 32'h66, 0, 1);
    checkOutput("rename_wins_match_x9", 5'd9, 4'd2, 32'h66);

    applyStimulus(1, 5'd0, 4'd7, 1, 5'd0, 4'd1, 32'h123, 0, 1);
    checkOutput("x0_hardwired", 5'd0, 4'd0, 32'd0);

    applyStimulus(1, 5'd3, 4'd5, 1, 5'd3, 4'd0, 32'h333, 0, 0);
    checkOutput("frozen_x3", 5'd3, 4'd0, 32'd0);
    applyStimulus(0, 5'd0, 4'd0, 1, 5'd5, 4'd0, 32'hBAD, 0, 0);
    checkOutput("frozen_x5", 5'd5, 4'd0, 32'hDEADBEEF);

    query = 1'b0; query_index = 5'd5;
    #1;
    checkCount++;
    assert (query_value === 32'd0 && query_entry === 4'd0) else begin
      failCount++;
      $error("[TB] FAIL query_off observed=%0d/0x%08h expected=0/0x00000000", query_entry, query_value);
    end

    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 5'(i), 4'(i + 8), 0, 5'd0, 4'd0, 32'd0, 0, 1);
    end
    checkOutput("pre_flush_x2", 5'd2, 4'd10, 32'd0);
    applyStimulus(1, 5'd2, 4'd5, 1, 5'd4, 4'd1, 32'h44, 1, 1);
    checkOutput("flush_x1", 5'd1, 4'd0, 32'd0);
    checkOutput("flush_x2", 5'd2, 4'd0, 32'd0);
    checkOutput("flush_x3", 5'd3, 4'd0, 32'd0);
    checkOutput("flush_x4", 5'd4, 4'd0, 32'h44);
    checkOutput("flush_x9", 5'd9, 4'd0, 32'h66);

    applyStimulus(1, 5'd8, 4'd3, 0, 5'd0, 4'd0, 32'd0, 0, 1);
    modify = 1'b1; modify_index = 5'd8; modify_entry = 4'd3; modify_value = 32'hAB;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_x8", 5'd8, 4'd0, 32'hAB);
`else
    checkOutput("no_bypass_x8", 5'd8, 4'd3, 32'd0);
`endif
    @(posedge clk_in); #1;
    idleInputs();
    checkOutput("after_commit_x8", 5'd8, 4'd0, 32'hAB);

    applyStimulus(1, 5'd7, 4'd9, 0, 5'd0, 4'd0, 32'd0, 0, 1);
    #2;
    rst_in = 1'b0;
    checkOutput("async_reset_x5", 5'd5, 4'd0, 32'd0);
    checkOutput("async_reset_x7", 5'd7, 4'd0, 32'd0);
    #3;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    checkOutput("post_reset_x5", 5'd5, 4'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
